stream_pretrig_ctrl: RTL and testbench

Triggered AXI-Stream frame gate with a pre-trigger ring buffer, placed between an ADC/DSP sample source and a DMA sink. Once armed it continuously buffers the most recent `pre_samples` input beats. On a selectable trigger edge it emits one frame of exactly `samples` beats: the buffered history first, then live data. The frame ends with `tlast`. Single-shot and continuous re-arm modes are supported.

---
 rtl/stream_pretrig_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_stream_pretrig_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_pretrig_ctrl.sv
// Triggered AXI-Stream frame gate: keeps a ring of recent input beats while armed,
// then emits one fixed-length frame (history first, then live data) per trigger edge.
module stream_pretrig_ctrl #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned PRE_DEPTH  = 1024,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [CNT_WIDTH-1:0]        samples,
    input  logic [$clog2(PRE_DEPTH):0]  pre_samples,
    input  logic                        continuous,
    input  logic                        trig_falling,
    input  logic                        arm,
    input  logic                        abort,
    input  logic                        trig,
    input  logic [DATA_WIDTH-1:0]       stream_i_tdata,
    input  logic                        stream_i_tvalid,
    output logic                        stream_i_tready,
    output logic [DATA_WIDTH-1:0]       stream_o_tdata,
    output logic                        stream_o_tvalid,
    output logic                        stream_o_tlast,
    input  logic                        stream_o_tready,
    output logic                        armed,
    output logic                        busy,
    output logic                        frame_done,
    output logic [15:0]                 frame_count
);
    localparam int unsigned ADDR_W = $clog2(PRE_DEPTH);
    localparam int unsigned OCC_W  = ADDR_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(PRE_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_ARMED,
        ST_DRAIN
    } state_t;

    state_t                 state;
    state_t                 state_next;

    logic [DATA_WIDTH-1:0]  mem [PRE_DEPTH];
    logic [ADDR_W-1:0]      wr_ptr;
    logic [ADDR_W-1:0]      rd_ptr;
    logic [OCC_W-1:0]       occ;
    logic                   trig_d;
    logic [CNT_WIDTH-1:0]   samples_q;
    logic [OCC_W-1:0]       pre_q;
    logic                   falling_q;
    logic [CNT_WIDTH-1:0]   wr_rem;
    logic [CNT_WIDTH-1:0]   rd_cnt;

    logic                   in_ready;
    logic                   out_valid;
    logic                   out_last;
    logic                   wr_en;
    logic                   rd_en;
    logic                   flush;
    logic                   latch_cfg;
    logic                   load_drain;
    logic                   done_set;
    logic                   trig_edge;
    logic                   at_depth;
    logic                   full;
    logic [CNT_WIDTH-1:0]   occ_ext;

    assign trig_edge = falling_q ? (~trig & trig_d) : (trig & ~trig_d);
    assign at_depth  = (occ == pre_q);
    assign full      = (occ == DEPTH_OCC);
    assign occ_ext   = CNT_WIDTH'(occ);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, handshakes and buffer control
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        flush      = 1'b0;
        latch_cfg  = 1'b0;
        load_drain = 1'b0;
        done_set   = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (arm) begin
                    state_next = ST_FILL;
                    latch_cfg  = 1'b1;
                end
            end
            ST_FILL, ST_ARMED: begin
                in_ready = 1'b1;
                // Once the history is deep enough, each new beat retires the oldest one
                if (stream_i_tvalid) begin
                    if (!at_depth) begin
                        wr_en = 1'b1;
                    end else if (pre_q != '0) begin
                        wr_en = 1'b1;
                        rd_en = 1'b1;
                    end
                end
                if (state == ST_FILL) begin
                    if (at_depth) begin
                        state_next = ST_ARMED;
                    end
                end else if (trig_edge) begin
                    state_next = ST_DRAIN;
                    load_drain = 1'b1;
                end
            end
            ST_DRAIN: begin
                in_ready  = (wr_rem != '0) && !full;
                out_valid = (occ != '0);
                out_last  = out_valid && (rd_cnt == samples_q - CNT_WIDTH'(1));
                wr_en     = in_ready && stream_i_tvalid;
                rd_en     = out_valid && stream_o_tready;
                if (out_last && stream_o_tready) begin
                    flush    = 1'b1;
                    done_set = 1'b1;
                    if (continuous) begin
                        state_next = ST_FILL;
                        latch_cfg  = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (abort) begin
            state_next = ST_IDLE;
            wr_en      = 1'b0;
            rd_en      = 1'b0;
            flush      = 1'b1;
            latch_cfg  = 1'b0;
            load_drain = 1'b0;
            done_set   = 1'b0;
        end
        // Abort and reset withdraw the stream handshakes immediately
        if (abort || reset) begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
            out_last  = 1'b0;
        end
    end

    // Buffer storage, written on accepted input beats
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= stream_i_tdata;
        end
    end

    // Pointers, occupancy, configuration and frame counters
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
            trig_d      <= 1'b0;
            samples_q   <= '0;
            pre_q       <= '0;
            falling_q   <= 1'b0;
            wr_rem      <= '0;
            rd_cnt      <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            trig_d <= trig;

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                end
                if (rd_en) begin
                    rd_ptr <= rd_ptr + ADDR_W'(1);
                end
                if (wr_en && !rd_en) begin
                    occ <= occ + OCC_W'(1);
                end else if (!wr_en && rd_en) begin
                    occ <= occ - OCC_W'(1);
                end
            end

            if (latch_cfg) begin
                samples_q <= (samples == '0) ? CNT_WIDTH'(1) : samples;
                pre_q     <= (pre_samples > DEPTH_OCC) ? DEPTH_OCC : pre_samples;
                falling_q <= trig_falling;
            end

            if (load_drain) begin
                wr_rem <= (samples_q > occ_ext) ? (samples_q - occ_ext) : '0;
                rd_cnt <= '0;
            end else if (state == ST_DRAIN) begin
                if (wr_en) begin
                    wr_rem <= wr_rem - CNT_WIDTH'(1);
                end
                if (rd_en) begin
                    rd_cnt <= rd_cnt + CNT_WIDTH'(1);
                end
            end

            frame_done <= done_set;
            if (done_set) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

    assign stream_i_tready = in_ready;
    assign stream_o_tvalid = out_valid;
    assign stream_o_tlast  = out_last;
    assign stream_o_tdata  = (occ != '0) ? mem[rd_ptr] : '0;
    assign armed           = (state == ST_ARMED);
    assign busy            = (state != ST_IDLE);

endmodule

// File: tb/tb_stream_pretrig_ctrl.sv
// Directed bench for stream_pretrig_ctrl: ramp source, captured output beats checked
// against hand-computed frames, plus control/status checks around each scenario.
module tb_stream_pretrig_ctrl;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CW    = 32;
    localparam int unsigned PW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            reset;
    logic [CW-1:0]   samples;
    logic [PW-1:0]   pre_samples;
    logic            continuous;
    logic            trig_falling;
    logic            arm;
    logic            abort;
    logic            trig;
    logic [DW-1:0]   stream_i_tdata;
    logic            stream_i_tvalid;
    logic            stream_i_tready;
    logic [DW-1:0]   stream_o_tdata;
    logic            stream_o_tvalid;
    logic            stream_o_tlast;
    logic            stream_o_tready;
    logic            armed;
    logic            busy;
    logic            frame_done;
    logic [15:0]     frame_count;

    always #5 clk = ~clk;

    stream_pretrig_ctrl #(
        .DATA_WIDTH (DW),
        .PRE_DEPTH  (DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .samples         (samples),
        .pre_samples     (pre_samples),
        .continuous      (continuous),
        .trig_falling    (trig_falling),
        .arm             (arm),
        .abort           (abort),
        .trig            (trig),
        .stream_i_tdata  (stream_i_tdata),
        .stream_i_tvalid (stream_i_tvalid),
        .stream_i_tready (stream_i_tready),
        .stream_o_tdata  (stream_o_tdata),
        .stream_o_tvalid (stream_o_tvalid),
        .stream_o_tlast  (stream_o_tlast),
        .stream_o_tready (stream_o_tready),
        .armed           (armed),
        .busy            (busy),
        .frame_done      (frame_done),
        .frame_count     (frame_count)
    );

    int n_checks = 0;
    int n_errors = 0;
    int src;
    int cyc;
    int last_cyc;
    int done_cyc;
    logic done_seen;
    logic busy_at_done;
    logic bp_en;
    logic prev_stall;
    logic [DW-1:0] prev_data;

    logic [DW-1:0] out_q[$];
    logic          last_q[$];
    logic [DW-1:0] exp_q[$];
    logic          expl_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: record handshakes before the edge, advance the ramp after it
    task automatic cycle();
        logic ihs;
        logic ohs;
        #1;
        ihs = stream_i_tvalid && stream_i_tready;
        ohs = stream_o_tvalid && stream_o_tready;
        prev_stall = stream_o_tvalid && !stream_o_tready;
        prev_data  = stream_o_tdata;
        if (ohs) begin
            out_q.push_back(stream_o_tdata);
            last_q.push_back(stream_o_tlast);
            if (stream_o_tlast) last_cyc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (ihs) src++;
        stream_i_tdata = DW'(src);
        if (bp_en && prev_stall) begin
            check_eq("bp_hold_valid", 32'(stream_o_tvalid), 32'd1);
            check_eq("bp_hold_data", 32'(stream_o_tdata), 32'(prev_data));
        end
        if (bp_en) stream_o_tready = 1'($urandom_range(1, 0));
        if (frame_done) begin
            done_seen    = 1'b1;
            done_cyc     = cyc;
            busy_at_done = busy;
        end
    endtask

    task automatic new_test();
        src = 0;
        stream_i_tdata = '0;
        done_seen = 1'b0;
        out_q.delete();
        last_q.delete();
        exp_q.delete();
        expl_q.delete();
    endtask

    task automatic push_frame(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(DW'(first + i));
            expl_q.push_back(i == n - 1);
        end
    endtask

    task automatic wait_src(input int target, input int budget, input string tag);
        for (int i = 0; i < budget && src != target; i++) cycle();
        check_eq(tag, 32'(src), 32'(target));
    endtask

    task automatic wait_done(input int budget, input string tag);
        for (int i = 0; i < budget && !done_seen; i++) cycle();
        check_eq(tag, 32'(done_seen), 32'd1);
    endtask

    task automatic check_stream(input string tag);
        check_eq({tag, "_len"}, 32'(out_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            check_eq($sformatf("%s_data%0d", tag, i), 32'(out_q[i]), 32'(exp_q[i]));
            check_eq($sformatf("%s_last%0d", tag, i), 32'(last_q[i]), 32'(expl_q[i]));
        end
    endtask

    initial begin
        reset = 1'b1;
        samples = 32'd10;
        pre_samples = PW'(4);
        continuous = 1'b0;
        trig_falling = 1'b0;
        arm = 1'b0;
        abort = 1'b0;
        trig = 1'b0;
        stream_i_tvalid = 1'b1;
        stream_o_tready = 1'b1;
        bp_en = 1'b0;
        prev_stall = 1'b0;
        prev_data = '0;
        cyc = 0;
        last_cyc = 0;
        done_cyc = 0;
        busy_at_done = 1'b0;
        new_test();

        cycle();
        cycle();
        reset = 1'b0;
        #1;
        check_eq("rst_i_tready", 32'(stream_i_tready), 32'd0);
        check_eq("rst_o_tvalid", 32'(stream_o_tvalid), 32'd0);
        check_eq("rst_o_tlast", 32'(stream_o_tlast), 32'd0);
        check_eq("rst_o_tdata", 32'(stream_o_tdata), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_count", 32'(frame_count), 32'd0);

        // Basic frame: pre 4, samples 10, edge on ramp beat 19
        new_test();
        arm = 1'b1;
        cycle();
        arm = 1'b0;
        check_eq("t1_busy_after_arm", 32'(busy), 32'd1);
        wait_src(19, 60, "t1_reach_edge");
        check_eq("t1_armed", 32'(armed), 32'd1);
        trig = 1'b1;
        cycle();
        trig = 1'b0;
        #1;
        check_eq("t1_first_valid", 32'(stream_o_tvalid), 32'd1);
        check_eq("t1_first_data", 32'(stream_o_tdata), 32'd16);
        wait_done(60, "t1_done_seen");
        push_frame(16, 10);
        check_stream("t1");
        check_eq("t1_done_latency", 32'(done_cyc), 32'(last_cyc + 1));
        check_eq("t1_busy_at_done", 32'(busy_at_done), 32'd0);
        check_eq("t1_count", 32'(frame_count), 32'd1);

        // Backpressure: same frame with random output tready
        new_test();
        bp_en = 1'b1;
        arm = 1'b1;
        cycle();
        arm = 1'b0;
        wait_src(19, 60, "t2_reach_edge");
        trig = 1'b1;
        cycle();
        trig = 1'b0;
        wait_done(300, "t2_done_seen");
        bp_en = 1'b0;
        stream_o_tready = 1'b1;
        push_frame(16, 10);
        check_stream("t2");
        check_eq("t2_count", 32'(frame_count), 32'd2);

        // Short frame: history deeper than the frame, leftovers flushed
        new_test();
        samples = 32'd3;
        pre_samples = PW'(8);
        arm = 1'b1;
        cycle();
        arm = 1'b0;
        wait_src(19, 60, "t3_reach_edge");
        trig = 1'b1;
        cycle();
        trig = 1'b0;
        #1;
        check_eq("t3_no_input", 32'(stream_i_tready), 32'd0);
        check_eq("t3_first_data", 32'(stream_o_tdata), 32'd12);
        wait_done(40, "t3_done_seen");
        push_frame(12, 3);
        check_stream("t3");
        check_eq("t3_src_after", 32'(src), 32'd20);
        #1;
        check_eq("t3_flushed_valid", 32'(stream_o_tvalid), 32'd0);
        check_eq("t3_flushed_data", 32'(stream_o_tdata), 32'd0);
        check_eq("t3_count", 32'(frame_count), 32'd3);

        // Falling trigger during FILL ignored; pre 20 clamps to full depth 16
        new_test();
        trig_falling = 1'b1;
        trig = 1'b1;
        samples = 32'd20;
        pre_samples = PW'(20);
        cycle();
        cycle();
        arm = 1'b1;
        cycle();
        arm = 1'b0;
        wait_src(5, 20, "t4_reach_fill_edge");
        trig = 1'b0;
        cycle();
        #1;
        check_eq("t4_fill_not_armed", 32'(armed), 32'd0);
        check_eq("t4_fill_no_valid", 32'(stream_o_tvalid), 32'd0);
        check_eq("t4_fill_busy", 32'(busy), 32'd1);
        wait_src(10, 20, "t4_reach_rise");
        trig = 1'b1;
        wait_src(29, 60, "t4_reach_edge");
        check_eq("t4_armed", 32'(armed), 32'd1);
        trig = 1'b0;
        stream_o_tready = 1'b0;
        cycle();
        #1;
        check_eq("t4_valid", 32'(stream_o_tvalid), 32'd1);
        check_eq("t4_first_data", 32'(stream_o_tdata), 32'd14);
        check_eq("t4_full_no_ready", 32'(stream_i_tready), 32'd0);
        cycle();
        cycle();
        #1;
        check_eq("t4_full_no_ready2", 32'(stream_i_tready), 32'd0);
        check_eq("t4_valid_held", 32'(stream_o_tvalid), 32'd1);
        check_eq("t4_src_held", 32'(src), 32'd30);
        stream_o_tready = 1'b1;
        wait_done(80, "t4_done_seen");
        push_frame(14, 20);
        check_stream("t4");
        check_eq("t4_count", 32'(frame_count), 32'd4);

        // Continuous re-arm: three 5-beat frames with no pre-trigger history
        new_test();
        trig_falling = 1'b0;
        trig = 1'b0;
        continuous = 1'b1;
        samples = 32'd5;
        pre_samples = PW'(0);
        cycle();
        arm = 1'b1;
        cycle();
        arm = 1'b0;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 20 && !armed; i++) cycle();
            check_eq($sformatf("t5_armed%0d", f), 32'(armed), 32'd1);
            push_frame(src + 1, 5);
            done_seen = 1'b0;
            trig = 1'b1;
            cycle();
            trig = 1'b0;
            wait_done(40, $sformatf("t5_done_seen%0d", f));
            check_eq($sformatf("t5_busy_at_done%0d", f), 32'(busy_at_done), 32'd1);
        end
        check_stream("t5");
        check_eq("t5_count", 32'(frame_count), 32'd7);
        continuous = 1'b0;
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        #1;
        check_eq("t5_idle_after_abort", 32'(busy), 32'd0);

        // Abort mid-frame after three output beats
        new_test();
        samples = 32'd10;
        pre_samples = PW'(4);
        arm = 1'b1;
        cycle();
        arm = 1'b0;
        wait_src(19, 60, "t6_reach_edge");
        trig = 1'b1;
        cycle();
        trig = 1'b0;
        for (int i = 0; i < 20 && out_q.size() < 3; i++) cycle();
        check_eq("t6_beats_before_abort", 32'(out_q.size()), 32'd3);
        abort = 1'b1;
        #1;
        check_eq("t6_abort_valid", 32'(stream_o_tvalid), 32'd0);
        check_eq("t6_abort_last", 32'(stream_o_tlast), 32'd0);
        check_eq("t6_abort_i_tready", 32'(stream_i_tready), 32'd0);
        cycle();
        abort = 1'b0;
        #1;
        check_eq("t6_idle_busy", 32'(busy), 32'd0);
        check_eq("t6_idle_valid", 32'(stream_o_tvalid), 32'd0);
        check_eq("t6_no_done", 32'(frame_done), 32'd0);
        check_eq("t6_count_kept", 32'(frame_count), 32'd7);
        check_eq("t6_beats_total", 32'(out_q.size()), 32'd3);
        begin
            int nl;
            nl = 0;
            foreach (last_q[i]) if (last_q[i]) nl++;
            check_eq("t6_no_tlast", 32'(nl), 32'd0);
        end

        // Reset during FILL clears every output
        arm = 1'b1;
        cycle();
        arm = 1'b0;
        cycle();
        #1;
        check_eq("t7_fill_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        #1;
        check_eq("t7_busy", 32'(busy), 32'd0);
        check_eq("t7_armed", 32'(armed), 32'd0);
        check_eq("t7_i_tready", 32'(stream_i_tready), 32'd0);
        check_eq("t7_o_tvalid", 32'(stream_o_tvalid), 32'd0);
        check_eq("t7_o_tlast", 32'(stream_o_tlast), 32'd0);
        check_eq("t7_o_tdata", 32'(stream_o_tdata), 32'd0);
        check_eq("t7_done", 32'(frame_done), 32'd0);
        check_eq("t7_count", 32'(frame_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
